// File: rtl/corner_reader.sv
// rtl/corner_reader.sv - raster-order corner detector with show-ahead corner record FIFO
module corner_reader #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  harris_in,
    input  logic [7:0]  threshold,
    output logic        c_valid,
    input  logic        c_ready,
    output logic [9:0]  c_x,
    output logic [8:0]  c_y,
    output logic [7:0]  c_score,
    output logic        frame_done,
    output logic [15:0] corner_count,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [9:0] X_LAST = 10'(IMG_W - 1);
    localparam logic [8:0] Y_LAST = 9'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t      state;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [15:0] tally;
    logic [15:0] tally_inc;

    logic [26:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [26:0] head;

    logic empty;
    logic full;
    logic pixel_take;
    logic corner;
    logic pop;
    logic push;
    logic last_px;

    // Pointer comparison with one extra wrap bit distinguishes full from empty
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    // The DONE cycle is a guaranteed gap, so en is ignored there
    assign pixel_take = en && (state != DONE);
    assign corner     = pixel_take && (harris_in > threshold);
    assign pop        = !empty && c_ready;
    // A full FIFO still accepts a corner when the head leaves in the same cycle
    assign push       = corner && (!full || pop);
    assign last_px    = (x == X_LAST) && (y == Y_LAST);
    assign tally_inc  = (corner && (tally != 16'hFFFF)) ? tally + 16'd1 : tally;

    // Show-ahead head; outputs read zero whenever no record is present
    assign head    = mem[rd_ptr[AW-1:0]];
    assign c_valid = !empty;
    assign c_y     = c_valid ? head[26:18] : 9'd0;
    assign c_x     = c_valid ? head[17:8]  : 10'd0;
    assign c_score = c_valid ? head[7:0]   : 8'd0;

    // Frame FSM: pixel coordinates, per-frame tally, frame_done pulse and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            x            <= 10'd0;
            y            <= 9'd0;
            tally        <= 16'd0;
            frame_done   <= 1'b0;
            corner_count <= 16'd0;
            overflow     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (corner && full && !pop) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE, SCAN: begin
                    if (pixel_take) begin
                        if (last_px) begin
                            state        <= DONE;
                            x            <= 10'd0;
                            y            <= 9'd0;
                            corner_count <= tally_inc;
                            tally        <= 16'd0;
                            frame_done   <= 1'b1;
                        end else begin
                            state <= SCAN;
                            tally <= tally_inc;
                            if (x == X_LAST) begin
                                x <= 10'd0;
                                y <= y + 9'd1;
                            end else begin
                                x <= x + 10'd1;
                            end
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO read/write pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {y, x, harris_in};
        end
    end
endmodule

// File: tb/tb_corner_reader.sv
// tb/tb_corner_reader.sv - directed self-checking bench for corner_reader
module tb_corner_reader;
    localparam int W = 20;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  harris_in = 8'd0;
    logic [7:0]  threshold = 8'd100;
    logic        c_valid;
    logic        c_ready = 1'b0;
    logic [9:0]  c_x;
    logic [8:0]  c_y;
    logic [7:0]  c_score;
    logic        frame_done;
    logic [15:0] corner_count;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    int n_rec;
    int f_x, f_y, l_x, l_y, l_s;

    corner_reader #(.IMG_W(W), .IMG_H(H), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .harris_in(harris_in),
        .threshold(threshold), .c_valid(c_valid), .c_ready(c_ready),
        .c_x(c_x), .c_y(c_y), .c_score(c_score), .frame_done(frame_done),
        .corner_count(corner_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One en pixel, driven and observed on falling edges
    task automatic pix(input logic [7:0] s);
        en = 1'b1;
        harris_in = s;
        @(negedge clk);
        en = 1'b0;
        harris_in = 8'd0;
    endtask

    // Pop everything for a fixed number of cycles, recording first/last record
    task automatic drain();
        n_rec = 0;
        c_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (c_valid) begin
                if (n_rec == 0) begin
                    f_x = int'(c_x);
                    f_y = int'(c_y);
                end
                l_x = int'(c_x);
                l_y = int'(c_y);
                l_s = int'(c_score);
                n_rec++;
            end
            @(negedge clk);
        end
        c_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_c_valid", c_valid, 0);
        check("rst_c_x", c_x, 0);
        check("rst_c_y", c_y, 0);
        check("rst_c_score", c_score, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_corner_count", corner_count, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Frame 1, row 0: single corner at x=5, equality at x=6 is not a corner
        c_ready = 1'b1;
        for (int x = 0; x < W; x++) begin
            pix(x == 5 ? 8'd101 : (x == 6 ? 8'd100 : 8'd0));
            if (x == 5) begin
                check("r0_c_valid", c_valid, 1);
                check("r0_c_x", c_x, 5);
                check("r0_c_y", c_y, 0);
                check("r0_c_score", c_score, 101);
            end
            if (x == 6) check("r0_eq_no_rec", c_valid, 0);
        end
        // Row 1: en toggles; corners at x=3 and x=11 must carry exact coordinates
        for (int x = 0; x < W; x++) begin
            pix((x == 3 || x == 11) ? 8'd200 : 8'd0);
            if (x == 3 || x == 11) begin
                check("r1_c_x", c_x, x);
                check("r1_c_y", c_y, 1);
            end
            @(negedge clk);
        end
        // Row 2: fill FIFO with 16 corners, then push+pop on a full FIFO
        c_ready = 1'b0;
        for (int x = 0; x < 16; x++) pix(8'd150);
        check("full_c_valid", c_valid, 1);
        check("full_head_x", c_x, 0);
        check("full_head_y", c_y, 2);
        check("full_no_ovf", overflow, 0);
        c_ready = 1'b1;
        pix(8'd151);
        c_ready = 1'b0;
        check("fullpp_no_ovf", overflow, 0);
        check("fullpp_head_x", c_x, 1);
        for (int p = 17; p < W * (H - 2); p++) pix(8'd0);
        check("f1_done_pulse", frame_done, 1);
        check("f1_count", corner_count, 20);
        @(negedge clk);
        check("f1_done_low", frame_done, 0);
        drain();
        check("f1_nrec", n_rec, 16);
        check("f1_first_x", f_x, 1);
        check("f1_first_y", f_y, 2);
        check("f1_last_x", l_x, 16);
        check("f1_last_s", l_s, 151);
        check("f1_ovf", overflow, 0);

        // Frame 2: corners at (0,0) and the last pixel, raster order
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                pix((x == 0 && y == 0) ? 8'd200 :
                    ((x == W - 1 && y == H - 1) ? 8'd201 : 8'd0));
        check("f2_done_pulse", frame_done, 1);
        check("f2_count", corner_count, 2);
        check("f2_head_x", c_x, 0);
        check("f2_head_y", c_y, 0);
        check("f2_head_s", c_score, 200);
        drain();
        check("f2_nrec", n_rec, 2);
        check("f2_last_x", l_x, W - 1);
        check("f2_last_y", l_y, H - 1);
        check("f2_last_s", l_s, 201);

        // Frame 3: 17 corners in row 2 with no draining
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                pix((y == 2 && x < 17) ? 8'd150 : 8'd0);
        check("f3_ovf", overflow, 1);
        check("f3_count", corner_count, 17);
        drain();
        check("f3_nrec", n_rec, 16);
        check("f3_first_x", f_x, 0);
        check("f3_first_y", f_y, 2);
        check("f3_last_x", l_x, 15);

        // Mid-frame reset with 3 records queued
        for (int p = 0; p < 3 * W + 10; p++)
            pix((p >= 1 && p <= 3) ? 8'd180 : 8'd0);
        check("mid_c_valid", c_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_c_valid", c_valid, 0);
        check("arst_ovf", overflow, 0);
        check("arst_count", corner_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pix(8'd250);
        check("post_rst_c_valid", c_valid, 1);
        check("post_rst_x", c_x, 0);
        check("post_rst_y", c_y, 0);
        check("post_rst_s", c_score, 250);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
